// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor engine: FSM states, STE start types and the
// per-STE configuration record.
package ltl_mon_pkg;

  // Field widths of the packed configuration record. The engine's SYM_W and
  // N_STATES parameters are expected to match these.
  localparam int unsigned STE_SYM_W = 8;
  localparam int unsigned STE_N     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_SOD  = 2'd1,
    START_ALL  = 2'd2
  } start_e;

  typedef struct packed {
    logic [STE_SYM_W-1:0] mask;
    logic [STE_SYM_W-1:0] value;
    logic [STE_N-1:0]     edges;
    start_e               start;
    logic                 report;
  } ste_cfg_t;

endpackage

// File: rtl/ltl_ste_cell.sv
// One state-transition element: configuration registers, symbol matcher,
// enable logic and the active flop.
module ltl_ste_cell
  import ltl_mon_pkg::*;
#(
  parameter int unsigned SYM_W    = STE_SYM_W,
  parameter int unsigned N_STATES = STE_N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  ste_cfg_t            cfg_wdata,
  input  logic                accept,
  input  logic                first_sym,
  input  logic                clear,
  input  logic [SYM_W-1:0]    sym,
  input  logic [N_STATES-1:0] active_vec,
  output logic                active,
  output logic                step,
  output logic                rep_en
);

  ste_cfg_t cfg_q, cfg_d;
  logic     active_q, active_d;
  logic     match, enable;

  // Would this STE be active if the offered symbol were accepted now
  always_comb begin
    match  = (sym & cfg_q.mask) == (cfg_q.value & cfg_q.mask);
    enable = ((active_vec & cfg_q.edges) != '0)
          || (cfg_q.start == START_ALL)
          || ((cfg_q.start == START_SOD) && first_sym);
    step   = match & enable;
  end

  // Next configuration and active bit; clear drops only the dynamic state
  always_comb begin
    cfg_d    = cfg_q;
    active_d = active_q;
    if (cfg_we) cfg_d = cfg_wdata;
    if (clear)       active_d = 1'b0;
    else if (accept) active_d = step;
  end

  // Configuration and active registers; reset empties the table entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;
  assign rep_en = cfg_q.report;

endmodule

// File: rtl/ltl_monitor_engine.sv
// Automaton-style monitor: N_STATES STEs stepped by an accepted symbol stream,
// with run/halt control, report aggregation and a saturating report counter.
module ltl_monitor_engine
  import ltl_mon_pkg::*;
#(
  parameter int unsigned SYM_W          = 8,
  parameter int unsigned N_STATES       = 16,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned STOP_ON_REPORT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        cfg_we,
  input  logic [$clog2(N_STATES)-1:0] cfg_idx,
  input  logic [SYM_W-1:0]            cfg_mask,
  input  logic [SYM_W-1:0]            cfg_value,
  input  logic [N_STATES-1:0]         cfg_edges,
  input  logic [1:0]                  cfg_start,
  input  logic                        cfg_report,
  output logic                        cfg_err,
  input  logic                        sym_valid,
  input  logic [SYM_W-1:0]            sym,
  output logic                        sym_ready,
  output logic [N_STATES-1:0]         active,
  output logic [N_STATES-1:0]         report,
  output logic                        report_any,
  output logic                        report_sticky,
  output logic [CNT_W-1:0]            report_cnt,
  output logic [1:0]                  busy
);

  localparam int unsigned IDX_W = $clog2(N_STATES);

  fsm_e             state_q, state_d;
  logic             first_q, first_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic [N_STATES-1:0] active_vec, step_vec, rep_mask;
  logic                accept, rep_hit, cfg_ok;
  ste_cfg_t            cfg_wdata;

  assign sym_ready = (state_q == ST_RUN);
  assign accept    = sym_valid && sym_ready;
  assign cfg_ok    = cfg_we && (state_q == ST_IDLE);
  // An accepted symbol that will leave a report STE active
  assign rep_hit   = accept && ((step_vec & rep_mask) != '0);
  assign cfg_wdata = '{mask: cfg_mask, value: cfg_value, edges: cfg_edges,
                       start: start_e'(cfg_start), report: cfg_report};

  for (genvar i = 0; i < N_STATES; i++) begin : g_ste
    ltl_ste_cell #(.SYM_W(SYM_W), .N_STATES(N_STATES)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_ok && (cfg_idx == IDX_W'(i))),
      .cfg_wdata (cfg_wdata),
      .accept    (accept),
      .first_sym (first_q),
      .clear     (clear),
      .sym       (sym),
      .active_vec(active_vec),
      .active    (active_vec[i]),
      .step      (step_vec[i]),
      .rep_en    (rep_mask[i])
    );
  end

  // FSM next state plus first-symbol flag, sticky, counter and error pulse
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    cfg_err_d = cfg_we && (state_q != ST_IDLE);
    if (clear) begin
      state_d  = ST_IDLE;
      first_d  = 1'b1;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end
        ST_RUN:  if (rep_hit && (STOP_ON_REPORT != 0)) state_d = ST_HALT;
        default: ;
      endcase
      if (accept) first_d = 1'b0;
      if (rep_hit) begin
        sticky_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      first_q   <= 1'b1;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign active        = active_vec;
  assign report        = active_vec & rep_mask;
  assign report_any    = |report;
  assign report_sticky = sticky_q;
  assign report_cnt    = cnt_q;
  assign busy          = state_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_ltl_monitor_engine.sv
// Directed bench: three engines share one stimulus stream -- default build,
// stop-on-report build and a 2-bit report counter build.
module tb_ltl_monitor_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, clear = 1'b0, cfg_we = 1'b0, cfg_report = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [7:0]  cfg_mask = '0, cfg_value = '0, sym = '0;
  logic [15:0] cfg_edges = '0;
  logic [1:0]  cfg_start = '0;
  logic        sym_valid = 1'b0;

  logic        a_err, a_rdy, a_any, a_stk;
  logic [15:0] a_act, a_rep, a_cnt;
  logic [1:0]  a_busy;
  logic        h_err, h_rdy, h_any, h_stk;
  logic [15:0] h_act, h_rep, h_cnt;
  logic [1:0]  h_busy;
  logic        s_err, s_rdy, s_any, s_stk;
  logic [15:0] s_act, s_rep;
  logic [1:0]  s_cnt;
  logic [1:0]  s_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ltl_monitor_engine u_dflt (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .cfg_edges(cfg_edges), .cfg_start(cfg_start), .cfg_report(cfg_report),
    .cfg_err(a_err), .sym_valid(sym_valid), .sym(sym), .sym_ready(a_rdy),
    .active(a_act), .report(a_rep), .report_any(a_any), .report_sticky(a_stk),
    .report_cnt(a_cnt), .busy(a_busy));

  ltl_monitor_engine #(.STOP_ON_REPORT(1)) u_halt (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .cfg_edges(cfg_edges), .cfg_start(cfg_start), .cfg_report(cfg_report),
    .cfg_err(h_err), .sym_valid(sym_valid), .sym(sym), .sym_ready(h_rdy),
    .active(h_act), .report(h_rep), .report_any(h_any), .report_sticky(h_stk),
    .report_cnt(h_cnt), .busy(h_busy));

  ltl_monitor_engine #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .cfg_edges(cfg_edges), .cfg_start(cfg_start), .cfg_report(cfg_report),
    .cfg_err(s_err), .sym_valid(sym_valid), .sym(sym), .sym_ready(s_rdy),
    .active(s_act), .report(s_rep), .report_any(s_any), .report_sticky(s_stk),
    .report_cnt(s_cnt), .busy(s_busy));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [7:0] mask, input logic [7:0] value,
                           input logic [15:0] edges, input logic [1:0] st, input logic rep);
    cfg_idx = idx; cfg_mask = mask; cfg_value = value;
    cfg_edges = edges; cfg_start = st; cfg_report = rep;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    sym_valid = 1'b1;
    sym = v;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_rdy_held", a_rdy, 1'b0);
    check_eq("rst_busy_held", a_busy, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rst_busy", a_busy, 2'd0);
    check_eq("rst_act", a_act, 16'h0);
    check_eq("rst_cnt", a_cnt, 16'h0);
    check_eq("rst_stk", a_stk, 1'b0);
    check_eq("rst_err", a_err, 1'b0);
    check_eq("rst_rdy", a_rdy, 1'b0);

    // Two-STE chain: any symbol, then 0x41 reports
    cfg_write(4'd0, 8'h00, 8'h00, 16'h0001, 2'd2, 1'b0);
    cfg_write(4'd1, 8'hFF, 8'h41, 16'h0001, 2'd0, 1'b1);
    pulse_start();
    check_eq("run_busy", a_busy, 2'd1);
    check_eq("run_rdy", a_rdy, 1'b1);
    send(8'h10);
    check_eq("chain_act0", a_act, 16'h0001);
    check_eq("chain_any0", a_any, 1'b0);
    send(8'h41);
    check_eq("chain_act1", a_act, 16'h0003);
    check_eq("chain_rep1", a_rep, 16'h0002);
    check_eq("chain_cnt1", a_cnt, 16'd1);
    check_eq("chain_stk1", a_stk, 1'b1);
    check_eq("chain_halt_busy", h_busy, 2'd2);
    send(8'h10);
    check_eq("chain_act2", a_act, 16'h0001);
    check_eq("chain_any2", a_any, 1'b0);
    check_eq("chain_stk_hold", a_stk, 1'b1);
    check_eq("chain_cnt_hold", a_cnt, 16'd1);
    check_eq("halt_stall_act", h_act, 16'h0003);

    // Start-of-data STE
    pulse_clear();
    check_eq("clr_busy", a_busy, 2'd0);
    check_eq("clr_act", a_act, 16'h0);
    check_eq("clr_cnt", a_cnt, 16'h0);
    check_eq("clr_stk", a_stk, 1'b0);
    cfg_write(4'd0, 8'hFF, 8'h05, 16'h0000, 2'd1, 1'b1);
    cfg_write(4'd1, 8'h00, 8'h00, 16'h0000, 2'd0, 1'b0);
    pulse_start();
    send(8'h05);
    check_eq("sod_any0", a_any, 1'b1);
    check_eq("sod_cnt0", a_cnt, 16'd1);
    send(8'h05);
    check_eq("sod_any1", a_any, 1'b0);
    check_eq("sod_cnt1", a_cnt, 16'd1);
    pulse_clear();
    pulse_start();
    send(8'h05);
    check_eq("sod_restart_any", a_any, 1'b1);
    check_eq("sod_restart_cnt", a_cnt, 16'd1);

    // Stop on report at the third symbol
    pulse_clear();
    cfg_write(4'd0, 8'hFF, 8'h01, 16'h0000, 2'd1, 1'b0);
    cfg_write(4'd1, 8'hFF, 8'h02, 16'h0001, 2'd0, 1'b0);
    cfg_write(4'd2, 8'hFF, 8'h03, 16'h0002, 2'd0, 1'b1);
    pulse_start();
    send(8'h01);
    send(8'h02);
    check_eq("stop_pre_busy", h_busy, 2'd1);
    send(8'h03);
    check_eq("stop_busy", h_busy, 2'd2);
    check_eq("stop_rdy", h_rdy, 1'b0);
    check_eq("stop_act", h_act, 16'h0004);
    check_eq("stop_cnt", h_cnt, 16'd1);
    send(8'h01);
    check_eq("stop_frozen", h_act, 16'h0004);
    check_eq("nostop_act", a_act, 16'h0000);
    check_eq("nostop_busy", a_busy, 2'd1);
    pulse_start();
    check_eq("start_in_halt", h_busy, 2'd2);
    pulse_clear();
    check_eq("stop_clr_busy", h_busy, 2'd0);
    check_eq("stop_clr_cnt", h_cnt, 16'd0);
    check_eq("stop_clr_act", h_act, 16'h0);

    // Counter saturation with a report on every symbol
    pulse_clear();
    cfg_write(4'd0, 8'h00, 8'h00, 16'h0000, 2'd2, 1'b1);
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'h77);
    check_eq("sat_cnt2", s_cnt, 2'd3);
    check_eq("sat_cnt16", a_cnt, 16'd5);

    // Rejected write while running, then start+clear together
    cfg_write(4'd0, 8'hFF, 8'h99, 16'h0000, 2'd0, 1'b0);
    check_eq("cfgerr_pulse", a_err, 1'b1);
    tick();
    check_eq("cfgerr_drop", a_err, 1'b0);
    send(8'h77);
    check_eq("cfgerr_unchanged", a_any, 1'b1);
    check_eq("cfgerr_cnt", a_cnt, 16'd6);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check_eq("clr_over_start", a_busy, 2'd0);
    cfg_write(4'd0, 8'h00, 8'h00, 16'h0000, 2'd2, 1'b1);
    check_eq("cfg_idle_noerr", a_err, 1'b0);

    // Asynchronous reset mid-stream
    pulse_start();
    send(8'h77);
    check_eq("pre_rst_any", a_any, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("arst_busy", a_busy, 2'd0);
    check_eq("arst_act", a_act, 16'h0);
    check_eq("arst_any", a_any, 1'b0);
    check_eq("arst_cnt", a_cnt, 16'h0);
    check_eq("arst_stk", a_stk, 1'b0);
    check_eq("arst_rdy", a_rdy, 1'b0);
    tick();
    reset = 1'b1;
    pulse_start();
    send(8'h77);
    check_eq("arst_tables_act", a_act, 16'h0);
    check_eq("arst_tables_any", a_any, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ltl_monitor_engine.md
LTL_MONITOR_ENGINE -- requirements
Module: ltl_monitor_engine

Interface
REQ-001 Parameters: SYM_W, 8, symbol width; N_STATES, 16, number of STEs; CNT_W, 16, report counter width; STOP_ON_REPORT, 0, stop the engine on the first report when 1.
REQ-002 Ports:
- clk, in, 1: single clock, all state updates on rising edge.
- reset, in, 1: reset, asynchronous and active-low.
- start, in, 1: pulse, IDLE->RUN.
- clear, in, 1: pulse, return to IDLE and clear the dynamic state.
- cfg_we, in, 1: configuration write strobe.
- cfg_idx, in, $clog2(N_STATES): STE being written.
- cfg_mask, in, SYM_W: symbol compare mask.
- cfg_value, in, SYM_W: symbol compare value.
- cfg_edges, in, N_STATES: predecessor vector; bit j set means an edge from STE j.
- cfg_start, in, 2: start type; 0 none, 1 start-of-data, 2 all-input.
- cfg_report, in, 1: STE is a report state.
- cfg_err, out, 1: one-cycle pulse when a write is rejected.
- sym_valid, in, 1: symbol valid.
- sym, in, SYM_W: input symbol.
- sym_ready, out, 1: engine accepts a symbol.
- active, out, N_STATES: registered active-state vector.
- report, out, N_STATES: active AND report mask.
- report_any, out, 1: OR of the report bits.
- report_sticky, out, 1: set on any report, held until clear.
- report_cnt, out, CNT_W: saturating count of accepted symbols that produced a report.
- busy, out, 2: FSM state; 0 IDLE, 1 RUN, 2 HALT.

Function
REQ-003 FSM states are IDLE, RUN and HALT; reset enters IDLE.
REQ-004 FSM transitions:
- IDLE->RUN on start.
- RUN->HALT when report_any rises and STOP_ON_REPORT=1.
- Any state->IDLE on clear.
- clear has priority over start in the same cycle.
REQ-005 cfg_we is honoured only in IDLE; a write in RUN or HALT leaves the tables unchanged and pulses cfg_err one cycle later.
REQ-006 sym_ready=1 only in RUN; a symbol is accepted on a cycle with sym_valid&&sym_ready.
REQ-007 Match rule: STE s matches when (sym & mask[s]) == (value[s] & mask[s]); mask=0 matches every symbol.
REQ-008 Enable rule, STE s is enabled on an accepted symbol when any of these holds:
- (active & edges[s]) != 0;
- start[s]==2;
- start[s]==1 and this is the first accepted symbol since entering RUN.
REQ-009 On an accepted symbol, active[s] <= match[s] & enable[s]; with no accepted symbol, active holds.
REQ-010 Latency: active, report and report_any reflect an accepted symbol on the following cycle.
REQ-011 report is combinational from the registered active and the report mask; no added latency.
REQ-012 report_cnt increments on each cycle where an accepted symbol yields report_any; it saturates at all-ones and does not wrap.
REQ-013 report_sticky sets on the same cycle report_any first asserts.
REQ-014 Entering HALT freezes active; sym_ready=0 from the cycle after the report, and stalled symbols are not consumed.
REQ-015 clear clears active, report_sticky, report_cnt and the first-symbol flag on the next edge; tables are retained.
REQ-016 start in RUN or HALT is ignored.
REQ-017 A self-edge keeps an STE active while its match holds.

Reset
REQ-018 On reset assertion, asynchronously:
- FSM=IDLE;
- active=0, report_sticky=0, report_cnt=0, cfg_err=0, first-symbol flag=1;
- all masks, values, edges, start types and report bits = 0, so no STE is ever enabled.
REQ-019 sym_ready=0 while reset is asserted.
REQ-020 Deassertion takes effect on the first rising clk edge thereafter.

Structure
REQ-021 Package ltl_mon_pkg holds:
- FSM state enum;
- start-type enum (START_NONE, START_SOD, START_ALL);
- per-STE config struct: mask, value, edges, start, report.
REQ-022 One sub-module, ltl_ste_cell, holds the per-STE config registers, matcher and active flop; it is instantiated N_STATES times by generate.

Verification
REQ-023 Configure STE0 as mask=0x00, start=ALL, self-edge and STE1 as mask=0xFF, value=0x41, edge from 0, report; start; drive 0x10,0x41 -> report[1]=1 one cycle after 0x41, report_cnt=1.
REQ-024 Configure STE0 with start=SOD, value=0x05, mask=0xFF, report; drive 0x05,0x05 -> report only after the first symbol; after clear+start, 0x05 reports again.
REQ-025 With STOP_ON_REPORT=1, a report on the 3rd symbol -> busy=HALT, sym_ready=0, active frozen; clear -> IDLE, report_cnt=0.
REQ-026 With CNT_W=2 and a report on every symbol, drive 5 symbols -> report_cnt=3.
REQ-027 cfg_we in RUN -> cfg_err pulses, behaviour unchanged; start and clear in the same cycle -> remains IDLE.
REQ-028 Assert reset mid-stream -> all outputs 0 asynchronously, sym_ready=0, tables cleared.
